// File: rtl/width_cast_pipe.sv
// Two-stage, back-pressured multi-lane width converter with four cast modes,
// per-lane lossy-cast flags and a saturating count of lossy output beats.
module width_cast_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int CH    = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [CH*IN_W-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*OUT_W-1:0] out_data,
    output logic [CH-1:0]       out_ovf,
    output logic [CNT_W-1:0]    sat_count,
    input  logic                clear_count
);

    localparam int WX = (IN_W > OUT_W) ? IN_W : OUT_W;

    // Returns {ovf, y} for one lane. Both extensions of x are built at the
    // wider of the two widths so every slice below stays in range.
    function automatic logic [OUT_W:0] cast_lane(input logic [IN_W-1:0] x,
                                                 input logic [1:0]      mode);
        logic [WX-1:0]    xz;
        logic [WX-1:0]    xs;
        logic [WX-1:0]    ys;
        logic [OUT_W-1:0] y;
        logic             ovf;
        logic             hi_nz;
        logic             s_fit;
        xz = '0;
        xz[IN_W-1:0] = x;
        xs = {WX{x[IN_W-1]}};
        xs[IN_W-1:0] = x;
        y = xz[OUT_W-1:0];
        ys = {WX{y[OUT_W-1]}};
        ys[OUT_W-1:0] = y;
        hi_nz = ((xz >> OUT_W) != '0);
        s_fit = (ys == xs);
        ovf = 1'b0;
        if (OUT_W >= IN_W) begin
            case (mode)
                2'b01, 2'b10: y = xs[OUT_W-1:0];
                default:      y = xz[OUT_W-1:0];
            endcase
        end else begin
            case (mode)
                2'b00: ovf = hi_nz;
                2'b01: ovf = !s_fit;
                2'b10: begin
                    ovf = !s_fit;
                    if (!s_fit) begin
                        y = {OUT_W{!xs[WX-1]}};
                        y[OUT_W-1] = xs[WX-1];
                    end else begin
                        y = xz[OUT_W-1:0];
                    end
                end
                2'b11: begin
                    ovf = hi_nz;
                    if (hi_nz) begin
                        y = '1;
                    end else begin
                        y = xz[OUT_W-1:0];
                    end
                end
                default: ovf = 1'b0;
            endcase
        end
        return {ovf, y};
    endfunction

    logic                s1_full_r;
    logic [CH*IN_W-1:0]  s1_data_r;
    logic [1:0]          s1_mode_r;
    logic                s2_full_r;
    logic [CH*OUT_W-1:0] out_data_r;
    logic [CH-1:0]       out_ovf_r;
    logic [CNT_W-1:0]    sat_count_r;

    logic                s2_adv_s;
    logic                s1_adv_s;
    logic                in_ready_s;
    logic [CH*OUT_W-1:0] cast_data_s;
    logic [CH-1:0]       cast_ovf_s;
    logic [OUT_W:0]      lane_s;

    // Handshake: in_ready passes out_ready straight through so a full pipe still streams.
    always_comb begin
        s2_adv_s   = !s2_full_r || out_ready;
        s1_adv_s   = s1_full_r && s2_adv_s;
        in_ready_s = !s1_full_r || s2_adv_s;
    end

    // Per-lane cast of the beat currently held in S1.
    always_comb begin
        cast_data_s = '0;
        cast_ovf_s  = '0;
        lane_s      = '0;
        for (int k = 0; k < CH; k++) begin
            lane_s = cast_lane(s1_data_r[k*IN_W +: IN_W], s1_mode_r);
            cast_data_s[k*OUT_W +: OUT_W] = lane_s[OUT_W-1:0];
            cast_ovf_s[k] = lane_s[OUT_W];
        end
    end

    // Stage 1: capture the raw beat and its mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full_r <= 1'b0;
            s1_data_r <= '0;
            s1_mode_r <= 2'b00;
        end else if (in_valid && in_ready_s) begin
            s1_full_r <= 1'b1;
            s1_data_r <= in_data;
            s1_mode_r <= in_mode;
        end else if (s1_adv_s) begin
            s1_full_r <= 1'b0;
        end
    end

    // Stage 2: register the cast result; data holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_full_r  <= 1'b0;
            out_data_r <= '0;
            out_ovf_r  <= '0;
        end else if (s1_adv_s) begin
            s2_full_r  <= 1'b1;
            out_data_r <= cast_data_s;
            out_ovf_r  <= cast_ovf_s;
        end else if (out_ready) begin
            s2_full_r  <= 1'b0;
        end
    end

    // Lossy-beat counter: clear beats a same-cycle increment, and it sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= '0;
        end else if (clear_count) begin
            sat_count_r <= '0;
        end else if (s1_adv_s && (|cast_ovf_s) && (sat_count_r != {CNT_W{1'b1}})) begin
            sat_count_r <= sat_count_r + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_full_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign sat_count = sat_count_r;

endmodule

// File: tb/tb_width_cast_pipe.sv
// Directed and randomized checks of width_cast_pipe in three configurations,
// against an integer-arithmetic model of the cast rules and a beat queue.
module tb_width_cast_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default configuration (a) and a CNT_W=2 twin (c) driven by the same inputs.
    logic        a_in_valid, a_out_ready, a_clear;
    logic [1:0]  a_in_mode;
    logic [7:0]  a_in_data;
    logic        a_in_ready, a_out_valid;
    logic [3:0]  a_out_data;
    logic [1:0]  a_out_ovf;
    logic [15:0] a_sat;
    logic        c_in_ready, c_out_valid;
    logic [3:0]  c_out_data;
    logic [1:0]  c_out_ovf;
    logic [1:0]  c_sat;
    // Widening configuration (b): IN_W=1, OUT_W=4, CH=1.
    logic        b_in_valid, b_out_ready, b_clear;
    logic [1:0]  b_in_mode;
    logic [0:0]  b_in_data;
    logic        b_in_ready, b_out_valid;
    logic [3:0]  b_out_data;
    logic [0:0]  b_out_ovf;
    logic [15:0] b_sat;

    width_cast_pipe dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
        .sat_count(a_sat), .clear_count(a_clear));

    width_cast_pipe #(.IN_W(4), .OUT_W(2), .CH(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(c_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(c_out_valid),
        .out_ready(a_out_ready), .out_data(c_out_data), .out_ovf(c_out_ovf),
        .sat_count(c_sat), .clear_count(a_clear));

    width_cast_pipe #(.IN_W(1), .OUT_W(4), .CH(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
        .sat_count(b_sat), .clear_count(b_clear));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cast of one lane value by plain arithmetic; result is (ovf << out_w) | y.
    function automatic int ref_lane(input int in_w, input int out_w, input int x, input int mode);
        int xs, val, ys, lo, hi, om, ovf;
        om  = (1 << out_w) - 1;
        xs  = (x >= (1 << (in_w - 1))) ? x - (1 << in_w) : x;
        ovf = 0;
        val = x;
        if (out_w >= in_w) begin
            val = (mode == 1 || mode == 2) ? xs : x;
        end else begin
            case (mode)
                0: ovf = (x > om) ? 1 : 0;
                1: begin
                    ys  = ((x & om) >= (1 << (out_w - 1))) ? (x & om) - (1 << out_w) : (x & om);
                    ovf = (ys != xs) ? 1 : 0;
                end
                2: begin
                    lo  = -(1 << (out_w - 1));
                    hi  = (1 << (out_w - 1)) - 1;
                    val = (xs < lo) ? lo : ((xs > hi) ? hi : xs);
                    ovf = (val != xs) ? 1 : 0;
                end
                default: begin
                    val = (x > om) ? om : x;
                    ovf = (x > om) ? 1 : 0;
                end
            endcase
        end
        return (ovf << out_w) | (val & om);
    endfunction

    // Expected {ovf[1:0], data[3:0]} for the default configuration.
    function automatic logic [5:0] ref_beat(input logic [7:0] d, input logic [1:0] m);
        logic [5:0] res;
        int r;
        res = 6'd0;
        for (int k = 0; k < 2; k++) begin
            r = ref_lane(4, 2, int'((d >> (4 * k)) & 8'hF), int'(m));
            res[2*k +: 2] = r[1:0];
            res[4+k]      = r[2];
        end
        return res;
    endfunction

    logic [5:0] exp_q[$];
    logic [5:0] held_v;
    logic [5:0] ref_v;
    logic       held;
    int         n_ovf;
    int         occ;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_clear = 1'b0; a_in_mode = 2'b00; a_in_data = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_clear = 1'b0; b_in_mode = 2'b00; b_in_data = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data", a_out_data, 4'h0);
        chk("rst_out_ovf", a_out_ovf, 2'b00);
        chk("rst_sat", a_sat, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1'b1);

        // Signed saturate, both lanes clamp; result two edges after presentation
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_mode = 2'b10; a_in_data = 8'b1000_0111;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("lat_not_early", a_out_valid, 1'b0);
        @(negedge clk);
        chk("sat10_valid", a_out_valid, 1'b1);
        chk("sat10_data", a_out_data, 4'b1001);
        chk("sat10_ovf", a_out_ovf, 2'b11);
        chk("sat10_count", a_sat, 16'd1);

        // Back-to-back beats in modes 01, 00, 11
        a_in_valid = 1'b1; a_in_mode = 2'b01; a_in_data = 8'b1111_0001;
        @(negedge clk);
        a_in_mode = 2'b00; a_in_data = 8'b0000_0110;
        @(negedge clk);
        a_in_mode = 2'b11; a_in_data = 8'b0011_0101;
        chk("m01_data", {a_out_ovf, a_out_data}, {2'b00, 4'b1101});
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("m00_data", {a_out_ovf, a_out_data}, {2'b01, 4'b0010});
        @(negedge clk);
        chk("m11_data", {a_out_ovf, a_out_data}, {2'b01, 4'b1111});
        @(negedge clk);
        chk("stream_end_valid", a_out_valid, 1'b0);
        chk("stream_count", a_sat, 16'd3);

        // Widening: IN_W=1 -> OUT_W=4
        b_in_valid = 1'b1; b_in_mode = 2'b01; b_in_data = 1'b1;
        @(negedge clk);
        b_in_mode = 2'b00;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("wide_sext", {b_out_valid, b_out_ovf, b_out_data}, {1'b1, 1'b0, 4'b1111});
        @(negedge clk);
        chk("wide_zext", {b_out_valid, b_out_ovf, b_out_data}, {1'b1, 1'b0, 4'b0001});

        // Back-pressure: A and B fill the pipe, C waits, then all drain in order
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_mode = 2'b00; a_in_data = 8'h21;
        #1 chk("bp_ready_a", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_data = 8'h03;
        #1 chk("bp_ready_b", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_data = 8'h12;
        #1 chk("bp_ready_c_low", a_in_ready, 1'b0);
        chk("bp_head_a", {a_out_valid, a_out_data}, {1'b1, 4'b1001});
        @(negedge clk);
        chk("bp_hold_a", {a_out_valid, a_out_data}, {1'b1, 4'b1001});
        #1 chk("bp_still_low", a_in_ready, 1'b0);
        a_out_ready = 1'b1;
        #1 chk("bp_ready_passthru", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("bp_out_b", {a_out_valid, a_out_data}, {1'b1, 4'b0011});
        @(negedge clk);
        chk("bp_out_c", {a_out_valid, a_out_data}, {1'b1, 4'b0110});
        @(negedge clk);
        chk("bp_no_dup", a_out_valid, 1'b0);

        // Counter saturation at CNT_W=2, then clear against a same-cycle load
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        chk("clr_a", a_sat, 16'd0);
        chk("clr_c", c_sat, 2'd0);
        a_in_valid = 1'b1; a_in_mode = 2'b10; a_in_data = 8'h77;
        repeat (5) @(negedge clk);
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt5_a", a_sat, 16'd5);
        chk("cnt_sat_c", c_sat, 2'd3);
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        chk("clr_win_valid", {a_out_valid, a_out_ovf}, {1'b1, 2'b11});
        chk("clr_win_a", a_sat, 16'd0);
        chk("clr_win_c", c_sat, 2'd0);
        @(negedge clk);
        chk("clr_win_after", a_sat, 16'd0);

        // Reset with both stages full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        a_in_valid = 1'b0;
        #1 chk("full_ready_low", a_in_ready, 1'b0);
        chk("full_sat", a_sat, 16'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_valid", a_out_valid, 1'b0);
        chk("mid_rst_sat", a_sat, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", a_in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", a_out_valid, 1'b0);
        end

        // Randomized traffic against the beat queue
        held = 1'b0;
        held_v = 6'd0;
        n_ovf = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            a_in_valid  = ($urandom_range(0, 9) < 7);
            a_out_ready = ($urandom_range(0, 9) < 6);
            a_in_mode   = 2'($urandom_range(0, 3));
            a_in_data   = 8'($urandom_range(0, 255));
            #1;
            occ = exp_q.size();
            chk("rnd_in_ready", a_in_ready, ((occ < 2) || a_out_ready) ? 1'b1 : 1'b0);
            if (held) begin
                chk("rnd_hold", {a_out_valid, a_out_ovf, a_out_data}, {1'b1, held_v});
            end
            held = 1'b0;
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", a_out_valid, 1'b0);
                end else begin
                    chk("rnd_data", {a_out_ovf, a_out_data}, exp_q[0]);
                    if (a_out_ready) begin
                        void'(exp_q.pop_front());
                    end else begin
                        held = 1'b1;
                        held_v = exp_q[0];
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                ref_v = ref_beat(a_in_data, a_in_mode);
                exp_q.push_back(ref_v);
                if (|ref_v[5:4]) n_ovf++;
            end
        end

        // Drain with a bounded budget
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (a_out_valid && exp_q.size() != 0) begin
                chk("drain_data", {a_out_ovf, a_out_data}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("rnd_sat_a", a_sat, (n_ovf > 65535) ? 65535 : n_ovf);
        chk("rnd_sat_c", c_sat, (n_ovf > 3) ? 3 : n_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
